// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared memory-interface definitions: block widths, arbiter
//               FSM encoding, grant types and the grant-select function.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Block address covers byte-address bits [31:4]; one block is 16 bytes.
  localparam int BLK_ADDR_W = 28;
  localparam int BLK_DATA_W = 128;

  // Arbiter FSM encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  typedef struct packed {
    logic  valid;
    side_e side;
  } grant_t;

  // Grant decision. Only IDLE can produce a grant. On a tie the fair
  // variant hands the bus to the side that was not served last, the
  // unfair variant always favours the I side.
  function automatic grant_t grant_sel(
    input logic [1:0] state,
    input logic       req_i,
    input logic       req_d,
    input side_e      last,
    input logic       fair
  );
    grant_t g;
    g.valid = 1'b0;
    g.side  = SIDE_I;
    if (state == ST_IDLE) begin
      if (req_i && req_d) begin
        g.valid = 1'b1;
        g.side  = (fair && (last == SIDE_I)) ? SIDE_D : SIDE_I;
      end else if (req_i) begin
        g.valid = 1'b1;
        g.side  = SIDE_I;
      end else if (req_d) begin
        g.valid = 1'b1;
        g.side  = SIDE_D;
      end
    end
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bus bundle between the I-cache, the D-cache, the arbiter
//               and the shared slow memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // I-cache side
  logic                  read_I;
  logic                  write_I;
  logic [BLK_ADDR_W-1:0] addr_I;
  logic [BLK_DATA_W-1:0] wdata_I;
  logic [BLK_DATA_W-1:0] rdata_I;
  logic                  ready_I;

  // D-cache side
  logic                  read_D;
  logic                  write_D;
  logic [BLK_ADDR_W-1:0] addr_D;
  logic [BLK_DATA_W-1:0] wdata_D;
  logic [BLK_DATA_W-1:0] rdata_D;
  logic                  ready_D;

  // Shared memory side
  logic                  mem_read;
  logic                  mem_write;
  logic [BLK_ADDR_W-1:0] mem_addr;
  logic [BLK_DATA_W-1:0] mem_wdata;
  logic [BLK_DATA_W-1:0] mem_rdata;
  logic                  mem_ready;

  // Arbiter view.
  modport slave (
    input  read_I, write_I, addr_I, wdata_I,
    input  read_D, write_D, addr_D, wdata_D,
    input  mem_rdata, mem_ready,
    output rdata_I, ready_I, rdata_D, ready_D,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  // Environment view (caches plus memory).
  modport master (
    output read_I, write_I, addr_I, wdata_I,
    output read_D, write_D, addr_D, wdata_D,
    output mem_rdata, mem_ready,
    input  rdata_I, ready_I, rdata_D, ready_D,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (I-cache / D-cache) arbiter in front of one
//               shared slow memory. Non-aborting grants, one-cycle ready
//               pulse, mandatory one-cycle release gap, registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  logic [1:0]            state_q,     state_d;
  side_e                 last_q,      last_d;
  logic                  mem_read_q,  mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [BLK_ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [BLK_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic                  readyI_q,    readyI_d;
  logic                  readyD_q,    readyD_d;
  logic [BLK_DATA_W-1:0] rdata_q,     rdata_d;

  logic                  req_i;
  logic                  req_d;
  grant_t                grant;

  assign req_i = bus.read_I | bus.write_I;
  assign req_d = bus.read_D | bus.write_D;
  assign grant = grant_sel(state_q, req_i, req_d, last_q, (FAIR != 0));

  // Next-state logic: capture the winner's request on grant, hold it
  // untouched until memory completes, then pulse ready and release.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    readyI_d    = 1'b0;
    readyD_d    = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant.valid) begin
          last_d = grant.side;
          if (grant.side == SIDE_I) begin
            state_d     = ST_GRANT_I;
            // A combined read+write request goes out as a write only.
            mem_write_d = bus.write_I;
            mem_read_d  = bus.read_I & ~bus.write_I;
            mem_addr_d  = bus.addr_I;
            mem_wdata_d = bus.wdata_I;
          end else begin
            state_d     = ST_GRANT_D;
            mem_write_d = bus.write_D;
            mem_read_d  = bus.read_D & ~bus.write_D;
            mem_addr_d  = bus.addr_D;
            mem_wdata_d = bus.wdata_D;
          end
        end
      end

      ST_GRANT_I, ST_GRANT_D: begin
        if (bus.mem_ready) begin
          // Writes leave the shared read block as it was.
          if (mem_read_q) begin
            rdata_d = bus.mem_rdata;
          end
          readyI_d    = (state_q == ST_GRANT_I);
          readyD_d    = (state_q == ST_GRANT_D);
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // Gap cycle lets the served requester drop its request before
        // the next arbitration round.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last grant resets to D so I wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= SIDE_D;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      readyI_q    <= 1'b0;
      readyD_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      readyI_q    <= readyI_d;
      readyD_q    <= readyD_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ready_I   = readyI_q;
  assign bus.ready_D   = readyD_q;
  assign bus.rdata_I   = rdata_q;
  assign bus.rdata_D   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed bench for mem_arbiter: a cycle table on a FAIR=1
//               instance plus hand sequences for reset and FAIR=0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam logic [27:0]  A_I  = 28'h0000010;
  localparam logic [27:0]  A_D  = 28'h0000020;
  localparam logic [127:0] WD_I = {16{8'h5A}};
  localparam logic [127:0] WD_D = {16{8'hA5}};
  localparam int           NVEC = 31;

  logic clk;
  logic rst_n;

  mem_arbiter_if bus_f();
  mem_arbiter_if bus_u();

  mem_arbiter #(.FAIR(1)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bus_f.slave));
  mem_arbiter #(.FAIR(0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus: req = {read_I, write_I, read_D, write_D}.
  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic        mrdy;
    logic [7:0]  mbyte;
    logic        e_mr;
    logic        e_mw;
    logic [27:0] e_addr;
    logic        e_rdyI;
    logic        e_rdyD;
    logic [7:0]  e_byte;
  } vec_t;

  vec_t vt [NVEC];
  int   n_chk;
  int   n_fail;

  function automatic vec_t v(input logic rst, input logic [3:0] req,
                             input logic mrdy, input logic [7:0] mb,
                             input logic emr, input logic emw,
                             input logic [27:0] ea, input logic eri,
                             input logic erd, input logic [7:0] eb);
    vec_t r;
    r.rst = rst; r.req = req; r.mrdy = mrdy; r.mbyte = mb;
    r.e_mr = emr; r.e_mw = emw; r.e_addr = ea;
    r.e_rdyI = eri; r.e_rdyD = erd; r.e_byte = eb;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nA5;
    logic prev_mw;

    n_chk  = 0;
    n_fail = 0;
    nA5    = 0;
    prev_mw = 1'b0;

    rst_n = 1'b0;
    bus_f.read_I = 0; bus_f.write_I = 0; bus_f.addr_I = A_I; bus_f.wdata_I = WD_I;
    bus_f.read_D = 0; bus_f.write_D = 0; bus_f.addr_D = A_D; bus_f.wdata_D = WD_D;
    bus_f.mem_ready = 0; bus_f.mem_rdata = '0;
    bus_u.read_I = 0; bus_u.write_I = 0; bus_u.addr_I = A_I; bus_u.wdata_I = WD_I;
    bus_u.read_D = 0; bus_u.write_D = 0; bus_u.addr_D = A_D; bus_u.wdata_D = WD_D;
    bus_u.mem_ready = 0; bus_u.mem_rdata = {16{8'h77}};

    //            rst req     rdy byte   mr mw addr rI rD byte
    vt[0]  = v(0, 4'b1000, 0, 8'h00,  1, 0, A_I, 0, 0, 8'h00);
    vt[1]  = v(0, 4'b1000, 0, 8'h00,  1, 0, A_I, 0, 0, 8'h00);
    vt[2]  = v(0, 4'b1000, 0, 8'h00,  1, 0, A_I, 0, 0, 8'h00);
    vt[3]  = v(0, 4'b1000, 0, 8'h00,  1, 0, A_I, 0, 0, 8'h00);
    vt[4]  = v(0, 4'b1000, 1, 8'h3C,  0, 0, A_I, 1, 0, 8'h3C);
    vt[5]  = v(0, 4'b0000, 0, 8'h00,  0, 0, A_I, 0, 0, 8'h3C);
    vt[6]  = v(0, 4'b0000, 1, 8'hFF,  0, 0, A_I, 0, 0, 8'h3C); // stray ready
    vt[7]  = v(0, 4'b0000, 0, 8'h00,  0, 0, A_I, 0, 0, 8'h3C);
    vt[8]  = v(1, 4'b0000, 0, 8'h00,  0, 0, 28'h0, 0, 0, 8'h00);
    vt[9]  = v(0, 4'b1001, 0, 8'h00,  1, 0, A_I, 0, 0, 8'h00); // tie -> I
    vt[10] = v(0, 4'b1001, 1, 8'h11,  0, 0, A_I, 1, 0, 8'h11);
    vt[11] = v(0, 4'b1001, 0, 8'h00,  0, 0, A_I, 0, 0, 8'h11);
    vt[12] = v(0, 4'b1001, 0, 8'h00,  0, 1, A_D, 0, 0, 8'h11); // tie -> D
    vt[13] = v(0, 4'b1001, 0, 8'h00,  0, 1, A_D, 0, 0, 8'h11);
    vt[14] = v(0, 4'b1001, 1, 8'h22,  0, 0, A_D, 0, 1, 8'h11); // write: no latch
    vt[15] = v(0, 4'b1010, 0, 8'h00,  0, 0, A_D, 0, 0, 8'h11);
    vt[16] = v(0, 4'b1010, 0, 8'h00,  1, 0, A_I, 0, 0, 8'h11); // tie -> I
    vt[17] = v(0, 4'b1010, 1, 8'h33,  0, 0, A_I, 1, 0, 8'h33);
    vt[18] = v(0, 4'b0010, 0, 8'h00,  0, 0, A_I, 0, 0, 8'h33);
    vt[19] = v(0, 4'b0010, 0, 8'h00,  1, 0, A_D, 0, 0, 8'h33); // D read
    vt[20] = v(0, 4'b0010, 1, 8'h44,  0, 0, A_D, 0, 1, 8'h44);
    vt[21] = v(0, 4'b0000, 0, 8'h00,  0, 0, A_D, 0, 0, 8'h44);
    vt[22] = v(0, 4'b1100, 0, 8'h00,  0, 1, A_I, 0, 0, 8'h44); // rd+wr -> wr
    vt[23] = v(0, 4'b1100, 1, 8'h55,  0, 0, A_I, 1, 0, 8'h44);
    vt[24] = v(0, 4'b0000, 0, 8'h00,  0, 0, A_I, 0, 0, 8'h44);
    vt[25] = v(0, 4'b0001, 0, 8'h00,  0, 1, A_D, 0, 0, 8'h44);
    vt[26] = v(0, 4'b0000, 0, 8'h00,  0, 1, A_D, 0, 0, 8'h44); // D dropped
    vt[27] = v(0, 4'b0000, 0, 8'h00,  0, 1, A_D, 0, 0, 8'h44);
    vt[28] = v(0, 4'b0000, 1, 8'h66,  0, 0, A_D, 0, 1, 8'h44);
    vt[29] = v(0, 4'b0000, 0, 8'h00,  0, 0, A_D, 0, 0, 8'h44);
    vt[30] = v(0, 4'b0000, 0, 8'h00,  0, 0, A_D, 0, 0, 8'h44);

    // Reset state.
    step();
    step();
    chk("rst_mem_read",  0, bus_f.mem_read,  1'b0);
    chk("rst_mem_write", 0, bus_f.mem_write, 1'b0);
    chk("rst_mem_addr",  0, bus_f.mem_addr,  28'h0);
    chk("rst_mem_wdata", 0, bus_f.mem_wdata, 128'h0);
    chk("rst_ready",     0, {bus_f.ready_I, bus_f.ready_D}, 2'b00);
    chk("rst_rdata",     0, bus_f.rdata_I,   128'h0);
    chk("rst_u_mem",     0, {bus_u.mem_read, bus_u.mem_write}, 2'b00);
    rst_n = 1'b1;

    // Cycle table on the FAIR=1 instance.
    for (int i = 0; i < NVEC; i++) begin
      rst_n           = !vt[i].rst;
      bus_f.read_I    = vt[i].req[3];
      bus_f.write_I   = vt[i].req[2];
      bus_f.read_D    = vt[i].req[1];
      bus_f.write_D   = vt[i].req[0];
      bus_f.mem_ready = vt[i].mrdy;
      bus_f.mem_rdata = {16{vt[i].mbyte}};
      step();
      chk("mem_read",  i + 1, bus_f.mem_read,  vt[i].e_mr);
      chk("mem_write", i + 1, bus_f.mem_write, vt[i].e_mw);
      chk("mem_addr",  i + 1, bus_f.mem_addr,  vt[i].e_addr);
      chk("ready_I",   i + 1, bus_f.ready_I,   vt[i].e_rdyI);
      chk("ready_D",   i + 1, bus_f.ready_D,   vt[i].e_rdyD);
      chk("rdata_I",   i + 1, bus_f.rdata_I,   {16{vt[i].e_byte}});
      chk("rdata_D",   i + 1, bus_f.rdata_D,   {16{vt[i].e_byte}});
      if (vt[i].e_mw)
        chk("mem_wdata", i + 1, bus_f.mem_wdata, (vt[i].e_addr == A_D) ? WD_D : WD_I);
      if (vt[i].rst)
        nA5 = 0;
      else if (bus_f.mem_write && !prev_mw && bus_f.mem_addr == A_D && bus_f.mem_wdata == WD_D)
        nA5++;
      prev_mw = bus_f.mem_write;
      if (i == 21)
        chk("a5_write_count", i + 1, nA5, 1);
    end
    bus_f.read_I = 0; bus_f.write_I = 0; bus_f.read_D = 0; bus_f.write_D = 0;
    bus_f.mem_ready = 0;

    // Reset while ready_D is being pulsed clears it without a clock edge.
    bus_f.write_D = 1;
    step();
    bus_f.mem_ready = 1;
    step();
    bus_f.mem_ready = 0;
    bus_f.write_D = 0;
    chk("pre_rst_ready_D", 100, bus_f.ready_D, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ready_D", 101, bus_f.ready_D, 1'b0);
    step();
    rst_n = 1'b1;

    // Reset mid GRANT_D drops the memory request asynchronously.
    bus_f.write_D = 1;
    step();
    chk("grant_d_mw", 102, bus_f.mem_write, 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_write", 103, bus_f.mem_write, 1'b0);
    chk("async_mem_read",  103, bus_f.mem_read,  1'b0);
    chk("async_mem_addr",  103, bus_f.mem_addr,  28'h0);
    chk("async_mem_wdata", 103, bus_f.mem_wdata, 128'h0);
    step();
    rst_n = 1'b1;
    bus_f.read_I = 1;
    bus_f.read_D = 1;
    bus_f.write_D = 0;
    step();
    chk("post_rst_grant_I", 104, {bus_f.mem_read, bus_f.mem_write}, 2'b10);
    chk("post_rst_addr",    104, bus_f.mem_addr, A_I);
    bus_f.read_I = 0;
    bus_f.read_D = 0;

    // FAIR=0: I keeps re-requesting and wins every tie; D waits for a gap.
    bus_u.write_D = 1;
    bus_u.read_I  = 1;
    for (int r = 0; r < 3; r++) begin
      step();
      chk("u_grant_I", 200 + r, {bus_u.mem_read, bus_u.mem_write}, 2'b10);
      chk("u_addr_I",  200 + r, bus_u.mem_addr, A_I);
      bus_u.mem_ready = 1;
      step();
      bus_u.mem_ready = 0;
      chk("u_ready_I", 200 + r, {bus_u.ready_I, bus_u.ready_D}, 2'b10);
      chk("u_rdata_I", 200 + r, bus_u.rdata_I, {16{8'h77}});
      step();
      chk("u_release", 200 + r, {bus_u.mem_read, bus_u.mem_write}, 2'b00);
    end
    bus_u.read_I = 0;
    step();
    chk("u_grant_D", 210, {bus_u.mem_read, bus_u.mem_write}, 2'b01);
    chk("u_addr_D",  210, bus_u.mem_addr, A_D);
    chk("u_wdata_D", 210, bus_u.mem_wdata, WD_D);
    bus_u.mem_ready = 1;
    step();
    bus_u.mem_ready = 0;
    bus_u.write_D = 0;
    chk("u_ready_D", 211, {bus_u.ready_I, bus_u.ready_D}, 2'b01);
    step();
    step();
    chk("u_idle", 212, {bus_u.mem_read, bus_u.mem_write, bus_u.ready_I, bus_u.ready_D}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FAIR, default 1: 1 = round-robin on simultaneous requests; 0 = I side always wins ties.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 read_I, write_I  input  1 each  I-cache read and write requests; held until ready_I.
REQ-005 addr_I  input  28  I-cache block address, bits [31:4].
REQ-006 wdata_I  input  128  I-cache write block.
REQ-007 rdata_I  output  128  read block to the I-cache; valid only while ready_I=1.
REQ-008 ready_I  output  1  one-cycle completion pulse to the I-cache.
REQ-009 read_D, write_D, addr_D, wdata_D, rdata_D, ready_D: the same as REQ-004..008, for the D-cache.
REQ-010 mem_read, mem_write  output  1 each  request to the shared slow memory.
REQ-011 mem_addr  output  28  block address to memory.
REQ-012 mem_wdata  output  128  write block to memory.
REQ-013 mem_rdata  input  128  read block from memory; valid while mem_ready=1.
REQ-014 mem_ready  input  1  memory completion, one or more cycles after the request.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, GRANT_I, GRANT_D and RELEASE.
REQ-016 In IDLE with a request on only one side, the FSM SHALL enter the GRANT state for that side.
REQ-017 In IDLE with requests on both sides, the winner SHALL be set by FAIR:
- FAIR=1: the side not granted last wins.
- FAIR=0: I wins.
REQ-018 When a GRANT state is entered, the arbiter SHALL register the winner's read, write, addr and wdata onto the mem_* outputs, so that mem_* is asserted one cycle after the request is sampled in IDLE.
REQ-019 While in a GRANT state, the mem_* outputs SHALL stay constant, even if the granted requester drops or changes its request (no abort).
REQ-020 A requester asserting read and write together SHALL be forwarded as a write only (mem_read=0).
REQ-021 In GRANT_x with mem_ready=1, the arbiter SHALL:
- latch mem_rdata into the shared read register;
- drive ready_x=1 for exactly the next cycle;
- deassert mem_read and mem_write in that same cycle;
- enter RELEASE.
REQ-022 RELEASE SHALL last exactly one cycle and then go to IDLE, so a request dropped after ready_x is never granted again.
REQ-023 rdata_I and rdata_D SHALL both be driven by the shared read register.
REQ-024 A write SHALL leave the shared read register unchanged.
REQ-025 mem_ready outside a GRANT state SHALL be ignored.
REQ-026 ready_I and ready_D SHALL never be 1 in the same cycle.
REQ-027 The last-grant register SHALL update on every entry to a GRANT state.
REQ-028 Minimum round trip SHALL be 3 cycles: request sampled -> mem_* asserted -> mem_ready -> ready_x.

Reset
REQ-029 Assertion of rst_n=0 SHALL take effect immediately, including mid-transaction; no memory completion is owed afterwards.
REQ-030 Reset values SHALL be:
- state = IDLE;
- mem_read = mem_write = 0;
- mem_addr = 0, mem_wdata = 0;
- ready_I = ready_D = 0;
- read register = 0;
- last-grant = D, so I wins the first tie.

Structure
REQ-031 The following SHALL live in the shared memory-interface package:
- FSM state encoding;
- block-address width (28) and block-data width (128).
REQ-032 The design SHALL be one flat module with no sub-module.
REQ-033 The grant-select decision SHALL be a single combinational function of {state, requests, last-grant, FAIR}.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Single I read, addr 0x0000010, memory with 4-cycle latency -> mem_read=1 with mem_addr=0x0000010 one cycle after the request; ready_I pulses once; rdata_I equals the memory block.
REQ-036 Simultaneous I read and D write (addr 0x0000020, wdata all-0xA5), FAIR=1, two back-to-back rounds -> first grant I, then D, then I, then D; exactly one write of all-0xA5 at 0x0000020.
REQ-037 Same stimulus with FAIR=0 and I re-requesting immediately after RELEASE -> the I side wins every tie, and the D side is served only in an idle window of the I side.
REQ-038 D requester drops write_D mid-grant -> mem_write stays 1 until mem_ready; ready_D pulses; no second memory transaction occurs.
REQ-039 rst_n pulsed low during GRANT_D -> mem_* and ready_* go to 0 asynchronously; after release, an I read is granted first.
REQ-040 Stray mem_ready in IDLE, and read_I with write_I asserted together -> the stray mem_ready causes no ready pulse; the combined request is forwarded as mem_write=1, mem_read=0.
